// File: rtl/store_alarm.sv
// Exit-scanner alarm: raises a blinking alarm on a stolen scan until the clerk
// acknowledges after a minimum hold time, and keeps saturating scan counts.
module store_alarm #(
    parameter int unsigned BLINK_HALF = 4,
    parameter int unsigned MIN_ALARM  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic       sale,
    input  logic       stolen,
    input  logic       ack,
    output logic       alarm_led,
    output logic       buzzer,
    output logic [3:0] stolen_cnt,
    output logic [3:0] sale_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_MAX   = 8'(MIN_ALARM);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);
    localparam logic [3:0] CNT_MAX    = 4'hF;

    state_t     state, state_n;
    logic [7:0] hold_tmr, hold_tmr_n;
    logic [7:0] blink_cnt, blink_cnt_n;
    logic       led_n, buzz_n;
    logic [3:0] stolen_cnt_n, sale_cnt_n;
    logic       stolen_hit, sale_hit;

    assign stolen_hit = scan_valid & stolen;
    assign sale_hit   = scan_valid & sale;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            hold_tmr   <= '0;
            blink_cnt  <= '0;
            alarm_led  <= 1'b0;
            buzzer     <= 1'b0;
            stolen_cnt <= '0;
            sale_cnt   <= '0;
        end else begin
            state      <= state_n;
            hold_tmr   <= hold_tmr_n;
            blink_cnt  <= blink_cnt_n;
            alarm_led  <= led_n;
            buzzer     <= buzz_n;
            stolen_cnt <= stolen_cnt_n;
            sale_cnt   <= sale_cnt_n;
        end
    end

    // Outputs are computed from the next state so the registered LED and
    // buzzer line up with the state register without extra latency.
    always_comb begin
        state_n     = state;
        hold_tmr_n  = hold_tmr;
        blink_cnt_n = blink_cnt;
        led_n       = 1'b0;
        buzz_n      = 1'b0;

        case (state)
            IDLE: begin
                if (stolen_hit) begin
                    state_n     = ALARM;
                    hold_tmr_n  = '0;
                    blink_cnt_n = '0;
                    led_n       = 1'b1;
                    buzz_n      = 1'b1;
                end
            end
            ALARM: begin
                if (ack && (hold_tmr == HOLD_MAX)) begin
                    state_n     = CLEAR;
                    hold_tmr_n  = '0;
                    blink_cnt_n = '0;
                end else begin
                    led_n = 1'b1;
                    if (hold_tmr != HOLD_MAX) begin
                        hold_tmr_n = hold_tmr + 8'd1;
                    end
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_n = '0;
                        buzz_n      = ~buzzer;
                    end else begin
                        blink_cnt_n = blink_cnt + 8'd1;
                        buzz_n      = buzzer;
                    end
                end
            end
            CLEAR: begin
                if (!ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        stolen_cnt_n = stolen_cnt;
        sale_cnt_n   = sale_cnt;
        if (stolen_hit && (stolen_cnt != CNT_MAX)) begin
            stolen_cnt_n = stolen_cnt + 4'd1;
        end
        if (sale_hit && (sale_cnt != CNT_MAX)) begin
            sale_cnt_n = sale_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_store_alarm.sv
// Directed bench for store_alarm with hand-computed expectations (defaults 4/8).
module tb_store_alarm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_valid = 1'b0;
    logic       sale = 1'b0;
    logic       stolen = 1'b0;
    logic       ack = 1'b0;
    logic       alarm_led;
    logic       buzzer;
    logic [3:0] stolen_cnt;
    logic [3:0] sale_cnt;

    int checks = 0;
    int errors = 0;

    store_alarm #(
        .BLINK_HALF(4),
        .MIN_ALARM (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_valid(scan_valid),
        .sale      (sale),
        .stolen    (stolen),
        .ack       (ack),
        .alarm_led (alarm_led),
        .buzzer    (buzzer),
        .stolen_cnt(stolen_cnt),
        .sale_cnt  (sale_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scan(input logic s_sale, input logic s_stolen);
        scan_valid = 1'b1;
        sale       = s_sale;
        stolen     = s_stolen;
    endtask

    task automatic noscan();
        scan_valid = 1'b0;
        sale       = 1'b0;
        stolen     = 1'b0;
    endtask

    initial begin
        // Reset held across an edge
        tick();
        check("rst_led", {7'd0, alarm_led}, 8'd0);
        check("rst_buz", {7'd0, buzzer}, 8'd0);
        check("rst_stc", {4'd0, stolen_cnt}, 8'd0);
        check("rst_slc", {4'd0, sale_cnt}, 8'd0);
        reset = 1'b0;
        tick();

        // Inputs ignored without scan_valid
        scan_valid = 1'b0; sale = 1'b1; stolen = 1'b1;
        tick();
        check("nv_led", {7'd0, alarm_led}, 8'd0);
        check("nv_stc", {4'd0, stolen_cnt}, 8'd0);
        check("nv_slc", {4'd0, sale_cnt}, 8'd0);

        // Sale scan only
        scan(1'b1, 1'b0);
        tick();
        noscan();
        check("sale_slc", {4'd0, sale_cnt}, 8'd1);
        check("sale_led", {7'd0, alarm_led}, 8'd0);
        tick();
        check("sale_led2", {7'd0, alarm_led}, 8'd0);

        // Sale + stolen on one scan
        scan(1'b1, 1'b1);
        tick();
        check("both_slc", {4'd0, sale_cnt}, 8'd2);
        check("both_stc", {4'd0, stolen_cnt}, 8'd1);
        check("both_led", {7'd0, alarm_led}, 8'd1);
        check("both_buz", {7'd0, buzzer}, 8'd1);
        scan(1'b0, 1'b1);
        tick();
        tick();
        noscan();
        check("pre_rst_stc", {4'd0, stolen_cnt}, 8'd3);
        check("pre_rst_led", {7'd0, alarm_led}, 8'd1);

        // Asynchronous reset between edges mid-ALARM
        #2 reset = 1'b1;
        #1;
        check("arst_led", {7'd0, alarm_led}, 8'd0);
        check("arst_buz", {7'd0, buzzer}, 8'd0);
        check("arst_stc", {4'd0, stolen_cnt}, 8'd0);
        check("arst_slc", {4'd0, sale_cnt}, 8'd0);
        #1 reset = 1'b0;
        tick();
        check("post_rst_led", {7'd0, alarm_led}, 8'd0);

        // Stolen scan, ack low for 20 cycles: buzzer 1111 0000 ...
        scan(1'b0, 1'b1);
        tick();
        noscan();
        check("al_led0", {7'd0, alarm_led}, 8'd1);
        check("al_buz0", {7'd0, buzzer}, 8'd1);
        check("al_stc", {4'd0, stolen_cnt}, 8'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("al_led", {7'd0, alarm_led}, 8'd1);
            check("al_buz", {7'd0, buzzer}, ((k / 4) % 2 == 0) ? 8'd1 : 8'd0);
        end
        ack = 1'b1;
        tick();
        check("clr_led", {7'd0, alarm_led}, 8'd0);
        check("clr_buz", {7'd0, buzzer}, 8'd0);
        tick();
        ack = 1'b0;
        tick();
        check("idle_led", {7'd0, alarm_led}, 8'd0);

        // ack held high: 8 cycles of ALARM after entry, then CLEAR
        ack = 1'b1;
        scan(1'b0, 1'b1);
        tick();
        noscan();
        check("hold_led0", {7'd0, alarm_led}, 8'd1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("hold_led", {7'd0, alarm_led}, 8'd1);
        end
        tick();
        check("hold_clr", {7'd0, alarm_led}, 8'd0);
        // Stolen scan while in CLEAR must not re-alarm
        scan(1'b0, 1'b1);
        tick();
        noscan();
        check("clr_scan_led", {7'd0, alarm_led}, 8'd0);
        check("clr_scan_stc", {4'd0, stolen_cnt}, 8'd3);
        tick();
        check("clr_stay", {7'd0, alarm_led}, 8'd0);
        // Scan on the CLEAR->IDLE edge is not evaluated as IDLE
        ack = 1'b0;
        scan(1'b0, 1'b1);
        tick();
        check("c2i_led", {7'd0, alarm_led}, 8'd0);
        check("c2i_stc", {4'd0, stolen_cnt}, 8'd4);
        tick();
        check("c2i_next_led", {7'd0, alarm_led}, 8'd1);
        check("c2i_next_stc", {4'd0, stolen_cnt}, 8'd5);

        // Scans during ALARM: counter saturates, timer/blink not restarted
        for (int k = 1; k <= 12; k++) begin
            ack = (k == 3);
            tick();
            check("sat_led", {7'd0, alarm_led}, 8'd1);
            check("sat_buz", {7'd0, buzzer}, ((k / 4) % 2 == 0) ? 8'd1 : 8'd0);
        end
        ack = 1'b0;
        noscan();
        check("sat_stc", {4'd0, stolen_cnt}, 8'd15);
        ack = 1'b1;
        tick();
        check("sat_clr", {7'd0, alarm_led}, 8'd0);
        ack = 1'b0;
        tick();
        check("sat_idle", {7'd0, alarm_led}, 8'd0);

        // Sale counter saturation in IDLE
        scan(1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("slc_ramp", {4'd0, sale_cnt}, (k >= 15) ? 8'd15 : 8'(k));
        end
        noscan();
        tick();
        check("slc_led", {7'd0, alarm_led}, 8'd0);
        check("stc_final", {4'd0, stolen_cnt}, 8'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_alarm.md
STORE_ALARM -- requirements
Module: store_alarm

Interface
REQ-001 Parameter BLINK_HALF, default 4: buzzer half-period in clk cycles, legal 1..255.
REQ-002 Parameter MIN_ALARM, default 8: minimum cycles in ALARM before ack is honoured, legal 1..255.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 scan_valid  input  1  one-cycle pulse: an item passed the exit scanner this cycle.
REQ-006 sale  input  1  sale light from the UPC lookup stage, sampled only when scan_valid=1.
REQ-007 stolen  input  1  stolen light from the UPC lookup stage, sampled only when scan_valid=1.
REQ-008 ack  input  1  clerk acknowledge switch, level-sensitive.
REQ-009 alarm_led  output  1  high while in ALARM.
REQ-010 buzzer  output  1  square wave while in ALARM, low otherwise.
REQ-011 stolen_cnt  output  4  saturating count of stolen scans since reset.
REQ-012 sale_cnt  output  4  saturating count of sale scans since reset.

Function
REQ-013 FSM shall have states IDLE, ALARM, CLEAR; all outputs registered.
REQ-014 IDLE -> ALARM on the edge where scan_valid=1 and stolen=1; alarm_led=1 and buzzer=1 from the next cycle (1-cycle latency).
REQ-015 On ALARM entry, the hold timer shall load 0 and the blink counter shall load 0.
REQ-016 In ALARM, the hold timer shall increment each cycle, saturating at MIN_ALARM.
REQ-017 In ALARM, buzzer shall toggle every BLINK_HALF cycles: high for the first BLINK_HALF cycles, then low for BLINK_HALF, repeating.
REQ-018 ALARM -> CLEAR on the edge where ack=1 and the timer equals MIN_ALARM; ack before then is ignored, with no latching.
REQ-019 CLEAR: alarm_led=0, buzzer=0; CLEAR -> IDLE on the first edge with ack=0.
REQ-020 Stolen scans arriving in ALARM or CLEAR shall not restart the timer or change state.
REQ-021 stolen_cnt shall increment on every edge with scan_valid=1 and stolen=1, in any state, saturating at 15.
REQ-022 sale_cnt shall increment on every edge with scan_valid=1 and sale=1, in any state, saturating at 15.
REQ-023 sale and stolen both high with scan_valid shall increment both counters in the same cycle and trigger the alarm from IDLE.
REQ-024 sale and stolen shall be ignored when scan_valid=0.
REQ-025 A stolen scan in the cycle of IDLE entry from CLEAR is evaluated in IDLE on the following edge only; the CLEAR->IDLE edge itself does not trigger ALARM.
REQ-026 The counters shall never wrap: 15 plus a further increment yields 15.

Reset
REQ-027 While reset=1: state IDLE, alarm_led=0, buzzer=0, stolen_cnt=0, sale_cnt=0, timers 0, regardless of clk.
REQ-028 Reset asserted mid-ALARM shall clear outputs asynchronously, without waiting for a clk edge.
REQ-029 After reset deasserts, the first edge with a stolen scan shall enter ALARM normally.

Verification
REQ-030 Sale scan (scan_valid=1, sale=1, stolen=0) -> sale_cnt 0->1, alarm_led stays 0.
REQ-031 Stolen scan, ack=0 held 20 cycles (defaults) -> alarm_led=1 from cycle+1; buzzer pattern 1111 0000 1111 ...; stolen_cnt=1.
REQ-032 Stolen scan, ack=1 continuously -> ALARM lasts exactly 8 cycles after entry before CLEAR; stays CLEAR until ack=0, then IDLE.
REQ-033 17 stolen scans including some during ALARM -> stolen_cnt saturates at 15; a single alarm, and the timer is not restarted.
REQ-034 sale=1 and stolen=1 on one scan -> both counters +1 and ALARM entered.
REQ-035 reset pulsed between clk edges during ALARM with counts 3/2 -> all outputs 0 immediately; the next stolen scan re-alarms.
